// File: rtl/ml_search_ctrl_pkg.sv
// Shared constants and types for the 4x4 QPSK ML search controller.
// ML_EARLY_EXIT_EN (optional) enables the early-exit threshold EXIT_THR.
package ml_search_ctrl_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 64;
    localparam int R_W   = 128;
    localparam int MET_W = 10;
    localparam int NCAND = 1 << X_W;

    localparam logic [MET_W-1:0] MET_MAX  = {MET_W{1'b1}};
    localparam logic [MET_W-1:0] EXIT_THR = {MET_W{1'b0}};

    localparam logic [X_W:0]   CNT_LAST = {1'b0, {X_W{1'b1}}};
    localparam logic [X_W:0]   CNT_ONE  = {{X_W{1'b0}}, 1'b1};
    localparam logic [X_W-1:0] X_ONE    = {{(X_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // True when the sweep counter points at the final candidate.
    function automatic logic is_last_cand(input logic [X_W:0] cnt);
        return (cnt == CNT_LAST);
    endfunction

endpackage

// File: rtl/ml_search_ctrl_if.sv
// Handshake and metric-unit bus of the ML search controller.
// master: controller side; slave: producer/metric unit/consumer side.
interface ml_search_ctrl_if;

    logic                                      in_valid;
    logic                                      in_ready;
    logic [ml_search_ctrl_pkg::Y_W-1:0]        in_y;
    logic [ml_search_ctrl_pkg::R_W-1:0]        in_r;
    logic [ml_search_ctrl_pkg::X_W-1:0]        cal_x;
    logic [ml_search_ctrl_pkg::Y_W-1:0]        cal_y;
    logic [ml_search_ctrl_pkg::R_W-1:0]        cal_r;
    logic [ml_search_ctrl_pkg::MET_W-1:0]      cal_result;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [ml_search_ctrl_pkg::X_W-1:0]        out_x;
    logic [ml_search_ctrl_pkg::MET_W-1:0]      out_metric;
    logic [ml_search_ctrl_pkg::X_W:0]          out_ncand;

    modport master (
        input  in_valid, in_y, in_r, cal_result, out_ready,
        output in_ready, cal_x, cal_y, cal_r, out_valid, out_x, out_metric, out_ncand
    );

    modport slave (
        output in_valid, in_y, in_r, cal_result, out_ready,
        input  in_ready, cal_x, cal_y, cal_r, out_valid, out_x, out_metric, out_ncand
    );

endinterface

// File: rtl/ml_min_tracker.sv
// Running-minimum tracker: the first compared entry is always taken, later
// entries replace the best only when strictly smaller (ties keep lower index).
module ml_min_tracker
    import ml_search_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [MET_W-1:0] met,
    input  logic [X_W-1:0]   idx,
    output logic [MET_W-1:0] best_met,
    output logic [X_W-1:0]   best_idx,
    output logic [X_W:0]     count
);

    logic [MET_W-1:0] best_met_r;
    logic [X_W-1:0]   best_idx_r;
    logic [X_W:0]     count_r;
    logic             take_s;

    // Decide whether the presented entry becomes the new best.
    always_comb begin
        take_s = 1'b0;
        if (valid && ((count_r == {(X_W+1){1'b0}}) || (met < best_met_r))) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Best-so-far registers and compared-entry counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_met_r <= {MET_W{1'b0}};
            best_idx_r <= {X_W{1'b0}};
            count_r    <= {(X_W+1){1'b0}};
        end else if (clear) begin
            best_met_r <= {MET_W{1'b0}};
            best_idx_r <= {X_W{1'b0}};
            count_r    <= {(X_W+1){1'b0}};
        end else if (valid) begin
            if (take_s) begin
                best_met_r <= met;
                best_idx_r <= idx;
            end
            count_r <= count_r + CNT_ONE;
        end
    end

    assign best_met = best_met_r;
    assign best_idx = best_idx_r;
    assign count    = count_r;

endmodule

// File: rtl/ml_search_ctrl.sv
// ML search controller: latches y/R, sweeps all candidates through the external
// combinational metric unit, tracks the minimum and returns the winner.
// Optional macro ML_EARLY_EXIT_EN: stop once a compared metric <= EXIT_THR.
module ml_search_ctrl
    import ml_search_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ml_search_ctrl_if.master   bus
);

    state_t           state_r;
    logic [X_W:0]     cnt_r;
    logic [X_W-1:0]   cal_x_r;
    logic [Y_W-1:0]   cal_y_r;
    logic [R_W-1:0]   cal_r_r;
    logic             in_ready_r;
    logic [MET_W-1:0] met_r;
    logic [X_W-1:0]   idx_r;
    logic             stg_vld_r;
    logic             out_valid_r;
    logic [X_W-1:0]   out_x_r;
    logic [MET_W-1:0] out_metric_r;
    logic [X_W:0]     out_ncand_r;

    logic             accept_s;
    logic             exit_s;
    logic [MET_W-1:0] best_met_s;
    logic [X_W-1:0]   best_idx_s;
    logic [X_W:0]     count_s;

    assign accept_s = bus.in_valid & in_ready_r;

`ifdef ML_EARLY_EXIT_EN
    assign exit_s = stg_vld_r & (met_r <= EXIT_THR);
`else
    assign exit_s = 1'b0;
`endif

    ml_min_tracker u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept_s),
        .valid    (stg_vld_r),
        .met      (met_r),
        .idx      (idx_r),
        .best_met (best_met_s),
        .best_idx (best_idx_s),
        .count    (count_s)
    );

    // Control FSM, sweep counter, operand latches, stage-1 pair and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {(X_W+1){1'b0}};
            cal_x_r      <= {X_W{1'b0}};
            cal_y_r      <= {Y_W{1'b0}};
            cal_r_r      <= {R_W{1'b0}};
            in_ready_r   <= 1'b1;
            met_r        <= {MET_W{1'b0}};
            idx_r        <= {X_W{1'b0}};
            stg_vld_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            out_x_r      <= {X_W{1'b0}};
            out_metric_r <= {MET_W{1'b0}};
            out_ncand_r  <= {(X_W+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        cal_y_r    <= bus.in_y;
                        cal_r_r    <= bus.in_r;
                        cnt_r      <= {(X_W+1){1'b0}};
                        cal_x_r    <= {X_W{1'b0}};
                        stg_vld_r  <= 1'b0;
                        in_ready_r <= 1'b0;
                        state_r    <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Capture this cycle's metric; it is compared next cycle.
                    met_r <= bus.cal_result;
                    idx_r <= cnt_r[X_W-1:0];
                    cnt_r <= cnt_r + CNT_ONE;
                    if (exit_s) begin
                        // Early exit drops the entry being captured now.
                        stg_vld_r <= 1'b0;
                        cal_x_r   <= {X_W{1'b0}};
                        state_r   <= DONE;
                    end else if (is_last_cand(cnt_r)) begin
                        stg_vld_r <= 1'b1;
                        cal_x_r   <= {X_W{1'b0}};
                        state_r   <= DRAIN;
                    end else begin
                        stg_vld_r <= 1'b1;
                        cal_x_r   <= cnt_r[X_W-1:0] + X_ONE;
                    end
                end
                DRAIN: begin
                    // Final stage-1 entry is compared during this cycle.
                    stg_vld_r <= 1'b0;
                    state_r   <= DONE;
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r  <= 1'b1;
                        out_x_r      <= best_idx_s;
                        out_metric_r <= best_met_s;
                        out_ncand_r  <= count_s;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    stg_vld_r   <= 1'b0;
                    out_valid_r <= 1'b0;
                    cal_x_r     <= {X_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.cal_x      = cal_x_r;
    assign bus.cal_y      = cal_y_r;
    assign bus.cal_r      = cal_r_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_x      = out_x_r;
    assign bus.out_metric = out_metric_r;
    assign bus.out_ncand  = out_ncand_r;

endmodule

// File: tb/tb_ml_search_ctrl.sv
// Self-checking bench for ml_search_ctrl with a table-driven metric model.
module tb_ml_search_ctrl;

    typedef struct {
        string        name;
        logic [7:0]   hot_a;
        logic [7:0]   hot_b;
        logic [9:0]   hot_met;
        logic [9:0]   base_met;
        logic [63:0]  y;
        logic [127:0] r;
        logic [7:0]   exp_x;
        logic [9:0]   exp_met;
        logic [8:0]   exp_ncand;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [9:0] model_met [256];
    vec_t vecs [6];

    ml_search_ctrl_if bus_if ();

    ml_search_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural metric unit: combinational lookup on the offered candidate.
    always_comb bus_if.cal_result = model_met[bus_if.cal_x];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input string what,
                       input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic set_model(input vec_t v);
        for (int i = 0; i < 256; i++) begin
            model_met[i] = v.base_met;
        end
        model_met[v.hot_a] = v.hot_met;
        model_met[v.hot_b] = v.hot_met;
    endtask

    task automatic start_txn(input vec_t v);
        set_model(v);
        @(negedge clk);
        bus_if.in_y     = v.y;
        bus_if.in_r     = v.r;
        bus_if.in_valid = 1'b1;
        chk(v.name, "in_ready_idle", bus_if.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        chk(v.name, "in_ready_busy", bus_if.in_ready, 1'b0);
    endtask

    task automatic wait_out(input string tag, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus_if.out_valid === 1'b1) seen = 1'b1;
        end
        chk(tag, "out_valid_seen", seen, 1'b1);
    endtask

    task automatic check_result(input vec_t v, input int edges);
`ifndef ML_EARLY_EXIT_EN
        chk(v.name, "latency", edges, 258);
`endif
        chk(v.name, "out_x", bus_if.out_x, v.exp_x);
        chk(v.name, "out_metric", bus_if.out_metric, v.exp_met);
        chk(v.name, "out_ncand", bus_if.out_ncand, v.exp_ncand);
        chk(v.name, "cal_y", bus_if.cal_y, v.y);
        chk(v.name, "cal_r", bus_if.cal_r, v.r);
        chk(v.name, "cal_x_done", bus_if.cal_x, 8'h00);
        chk(v.name, "in_ready_done", bus_if.in_ready, 1'b0);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        chk(tag, "out_valid_after_hs", bus_if.out_valid, 1'b0);
        chk(tag, "in_ready_after_hs", bus_if.in_ready, 1'b1);
    endtask

    task automatic do_txn(input vec_t v);
        int edges;
        start_txn(v);
        wait_out(v.name, edges);
        check_result(v, edges);
        handshake(v.name);
    endtask

    initial begin
        int   edges;
        int   stray;
        bit   hit;
        vec_t v2;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{"zero", 8'h00, 8'h00, 10'd0, 10'd0, 64'h0, 128'h0, 8'h00, 10'd0,
`ifdef ML_EARLY_EXIT_EN
                    9'd1};
`else
                    9'd256};
`endif
        vecs[1] = '{"single", 8'hA5, 8'hA5, 10'd3, 10'd100, 64'h0123_4567_89AB_CDEF,
                    128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 8'hA5, 10'd3, 9'd256};
        vecs[2] = '{"tie", 8'h10, 8'h80, 10'd7, 10'd50, 64'hFEDC_BA98_7654_3210,
                    128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 8'h10, 10'd7, 9'd256};
        vecs[3] = '{"allmax", 8'h00, 8'h00, 10'd1023, 10'd1023, 64'hAAAA_5555_AAAA_5555,
                    128'h5A5A_A5A5_5A5A_A5A5_5A5A_A5A5_5A5A_A5A5, 8'h00, 10'd1023, 9'd256};
        vecs[4] = '{"lastidx", 8'hFF, 8'hFF, 10'd2, 10'd9, 64'h1111_2222_3333_4444,
                    128'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0, 8'hFF, 10'd2, 9'd256};
        vecs[5] = '{"idx1zero", 8'h01, 8'h01, 10'd0, 10'd40, 64'h0000_0000_0000_0001,
                    128'h1, 8'h01, 10'd0,
`ifdef ML_EARLY_EXIT_EN
                    9'd2};
`else
                    9'd256};
`endif

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_y      = 64'h0;
        bus_if.in_r      = 128'h0;
        bus_if.out_ready = 1'b0;
        set_model(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "in_ready", bus_if.in_ready, 1'b1);
        chk("reset", "out_valid", bus_if.out_valid, 1'b0);
        chk("reset", "out_x", bus_if.out_x, 8'h00);
        chk("reset", "out_metric", bus_if.out_metric, 10'd0);
        chk("reset", "out_ncand", bus_if.out_ncand, 9'd0);
        chk("reset", "cal_x", bus_if.cal_x, 8'h00);
        chk("reset", "cal_y", bus_if.cal_y, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i]);
        end

        // Backpressure: result held, new offer ignored until the handshake.
        v2      = vecs[1];
        v2.name = "bp_next";
        v2.y    = 64'hDEAD_BEEF_CAFE_F00D;
        v2.r    = 128'hFFFF_0000_FFFF_0000_1234_0000_5678_0000;
        start_txn(vecs[1]);
        wait_out("bp", edges);
        check_result(vecs[1], edges);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus_if.in_valid = 1'b1;
            bus_if.in_y     = v2.y;
            bus_if.in_r     = v2.r;
            @(posedge clk);
            #1;
            chk("bp", "out_valid_held", bus_if.out_valid, 1'b1);
            chk("bp", "out_x_held", bus_if.out_x, 8'hA5);
            chk("bp", "out_metric_held", bus_if.out_metric, 10'd3);
            chk("bp", "in_ready_low", bus_if.in_ready, 1'b0);
            chk("bp", "cal_y_kept", bus_if.cal_y, vecs[1].y);
        end
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        chk("bp", "out_valid_after_hs", bus_if.out_valid, 1'b0);
        chk("bp", "in_ready_after_hs", bus_if.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        chk("bp", "accept_after_hs", bus_if.in_ready, 1'b0);
        chk("bp", "cal_y_new", bus_if.cal_y, v2.y);
        wait_out("bp_next", edges);
        check_result(v2, edges);
        handshake("bp_next");

        // Asynchronous reset in the middle of the sweep.
        start_txn(vecs[1]);
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.cal_x === 8'd100) hit = 1'b1;
        end
        chk("midrst", "reached_cnt100", hit, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst", "in_ready", bus_if.in_ready, 1'b1);
        chk("midrst", "out_valid", bus_if.out_valid, 1'b0);
        chk("midrst", "out_x", bus_if.out_x, 8'h00);
        chk("midrst", "out_metric", bus_if.out_metric, 10'd0);
        chk("midrst", "out_ncand", bus_if.out_ncand, 9'd0);
        chk("midrst", "cal_x", bus_if.cal_x, 8'h00);
        chk("midrst", "cal_y", bus_if.cal_y, 64'h0);
        chk("midrst", "cal_r", bus_if.cal_r, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid !== 1'b0) stray++;
        end
        chk("midrst", "no_out_valid", stray, 0);
        do_txn(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
